// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - pipeline hazard, forwarding and memory-wait controller
//
// Purpose: drives the E-stage forwarding muxes and the stall/flush enables of the
// F/D, D/E, E/M and M/W pipeline registers for a five-stage pipeline. It resolves
// load-use hazards, PC-write/branch redirects, and multi-cycle data-memory waits.
// The memory-wait FSM has a timeout watchdog and a sticky error flag.
//
// Optional feature macro: HAZARD_PERF_EN adds the StallCnt/FlushCnt/MemWaitCnt
// performance counters.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   RA1E, RA2E / RA1D, RA2D    source register addresses in E / D
//   WA3E, WA3M, WA3W           destination register addresses in E / M / W
//   RegWriteM, RegWriteW       register write enables in M / W
//   MemtoRegE                  the instruction in E is a load
//   PCWrPendingF, PCSrcW       PC write in flight (D/E/M) / PC write in W
//   BranchTakenE               branch resolved taken in E
//   MemReqM, MemReadyM         data access active in M / access completes this cycle
//   ForwardAE, ForwardBE       00 regfile, 01 ResultW, 10 ALUOutM
//   StallF/D/E/M               hold the pipeline register
//   FlushD/E/W                 clear the pipeline register (bubble)
//   MemErr                     sticky memory-timeout error
//   StallCnt, FlushCnt, MemWaitCnt (HAZARD_PERF_EN only) wrapping event counters

module hazard_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] RA1E,
  input  logic [3:0] RA2E,
  input  logic [3:0] RA1D,
  input  logic [3:0] RA2D,
  input  logic [3:0] WA3E,
  input  logic [3:0] WA3M,
  input  logic [3:0] WA3W,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       PCWrPendingF,
  input  logic       PCSrcW,
  input  logic       BranchTakenE,
  input  logic       MemReqM,
  input  logic       MemReadyM,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushW,
  output logic       MemErr
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] StallCnt,
  output logic [31:0] FlushCnt,
  output logic [31:0] MemWaitCnt
`endif
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t     state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic       mem_err, mem_err_next;
  logic       ldr_stall, mem_stall, timeout;

  // M has priority over W because it holds the younger result.
  function automatic logic [1:0] fwd_sel(input logic [3:0] ra);
    if (RegWriteM && (WA3M == ra))      return 2'b10;
    else if (RegWriteW && (WA3W == ra)) return 2'b01;
    else                                return 2'b00;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      mem_err <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      mem_err <= mem_err_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    mem_err_next = mem_err;
    ForwardAE    = 2'b00;
    ForwardBE    = 2'b00;
    StallF       = 1'b0;
    StallD       = 1'b0;
    StallE       = 1'b0;
    StallM       = 1'b0;
    FlushD       = 1'b0;
    FlushE       = 1'b0;
    FlushW       = 1'b0;
    MemErr       = 1'b0;

    ldr_stall = MemtoRegE && ((WA3E == RA1D) || (WA3E == RA2D));
    // The watchdog releases the stall in the same cycle it fires, so the
    // longest possible stall is MEM_TIMEOUT-1 cycles.
    timeout   = (state == S_WAIT) && (cnt == CNT_W'(MEM_TIMEOUT - 1)) && !MemReadyM;
    mem_stall = ((state == S_IDLE) && MemReqM && !MemReadyM) ||
                ((state == S_WAIT) && !MemReadyM && !timeout);

    case (state)
      S_IDLE: begin
        if (MemReqM && !MemReadyM) begin
          state_next = S_WAIT;
          cnt_next   = CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (MemReadyM || timeout) begin
          state_next = S_IDLE;
          cnt_next   = '0;
          if (timeout) mem_err_next = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase

    if (reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else begin
      ForwardAE = fwd_sel(RA1E);
      ForwardBE = fwd_sel(RA2E);
      MemErr    = mem_err;
      if (mem_stall) begin
        // Freeze the whole pipe; a pending branch or load-use in E is simply
        // held and acts once the access releases.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF = ldr_stall || PCWrPendingF;
        StallD = ldr_stall;
        FlushE = ldr_stall || BranchTakenE;
        FlushD = PCWrPendingF || PCSrcW || BranchTakenE;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      StallCnt   <= '0;
      FlushCnt   <= '0;
      MemWaitCnt <= '0;
    end else begin
      if (StallD) StallCnt <= StallCnt + 32'd1;
      // Only branch-caused flushes count; a held branch counts once, on release.
      if (BranchTakenE && !mem_stall) FlushCnt <= FlushCnt + 32'd1;
      if (mem_stall) MemWaitCnt <= MemWaitCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - self-checking bench for hazard_controller
module tb_hazard_controller;

  localparam int MEM_TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] RA1E, RA2E, RA1D, RA2D, WA3E, WA3M, WA3W;
  logic       RegWriteM, RegWriteW, MemtoRegE, PCWrPendingF, PCSrcW;
  logic       BranchTakenE, MemReqM, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
`ifdef HAZARD_PERF_EN
  logic [31:0] StallCnt, FlushCnt, MemWaitCnt;
`endif

  hazard_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .RA1E(RA1E), .RA2E(RA2E), .RA1D(RA1D), .RA2D(RA2D),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .PCWrPendingF(PCWrPendingF), .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemErr(MemErr)
`ifdef HAZARD_PERF_EN
    , .StallCnt(StallCnt), .FlushCnt(FlushCnt), .MemWaitCnt(MemWaitCnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: number of cycles the current access has already stalled
  // (0 = no access outstanding), the sticky error, and event counters.
  int          waited = 0;
  bit          err_m  = 0;
  logic [31:0] sc_m = 0, fc_m = 0, mc_m = 0;
  logic        last_stallf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd_m(input logic [3:0] ra);
    if (RegWriteM && WA3M == ra) return 2'b10;
    if (RegWriteW && WA3W == ra) return 2'b01;
    return 2'b00;
  endfunction

  // Checks every output for the current inputs, then clocks and advances the model.
  task automatic cycle();
    logic ldr, ms;
    logic [1:0] efa, efb;
    logic esf, esd, ese, esm, efd, efe, efw, eerr;
    #2;
    ldr = MemtoRegE && (WA3E == RA1D || WA3E == RA2D);
    ms  = !reset && (waited > 0 || MemReqM) && !MemReadyM && (waited < MEM_TIMEOUT - 1);
    if (reset) begin
      efa = 0; efb = 0; esf = 0; esd = 0; ese = 0; esm = 0;
      efd = 1; efe = 1; efw = 0; eerr = 0;
    end else begin
      efa = fwd_m(RA1E); efb = fwd_m(RA2E); eerr = err_m;
      if (ms) begin
        esf = 1; esd = 1; ese = 1; esm = 1; efd = 0; efe = 0; efw = 1;
      end else begin
        esf = ldr | PCWrPendingF; esd = ldr; ese = 0; esm = 0;
        efe = ldr | BranchTakenE; efd = PCWrPendingF | PCSrcW | BranchTakenE; efw = 0;
      end
    end
    chk("ForwardAE", 32'(ForwardAE), 32'(efa));
    chk("ForwardBE", 32'(ForwardBE), 32'(efb));
    chk("StallF", 32'(StallF), 32'(esf));
    chk("StallD", 32'(StallD), 32'(esd));
    chk("StallE", 32'(StallE), 32'(ese));
    chk("StallM", 32'(StallM), 32'(esm));
    chk("FlushD", 32'(FlushD), 32'(efd));
    chk("FlushE", 32'(FlushE), 32'(efe));
    chk("FlushW", 32'(FlushW), 32'(efw));
    chk("MemErr", 32'(MemErr), 32'(eerr));
`ifdef HAZARD_PERF_EN
    chk("StallCnt", StallCnt, sc_m);
    chk("FlushCnt", FlushCnt, fc_m);
    chk("MemWaitCnt", MemWaitCnt, mc_m);
`endif
    last_stallf = StallF;
    @(posedge clk);
    if (reset) begin
      waited = 0; err_m = 0; sc_m = 0; fc_m = 0; mc_m = 0;
    end else begin
      if (esd) sc_m = sc_m + 1;
      if (BranchTakenE && !ms) fc_m = fc_m + 1;
      if (ms) mc_m = mc_m + 1;
      if (ms) waited++;
      else if (waited > 0) begin
        if (!MemReadyM) err_m = 1;
        waited = 0;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; RA1E = 0; RA2E = 0; RA1D = 0; RA2D = 0;
    WA3E = 0; WA3M = 0; WA3W = 0;
    RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0; PCWrPendingF = 0; PCSrcW = 0;
    BranchTakenE = 0; MemReqM = 0; MemReadyM = 0;
  endtask

  initial begin
    int nst;
    int mode;
    idle_inputs();
    RA1E = 4'd7; WA3M = 4'd7; RegWriteM = 1;
    reset = 1;
    cycle();
    cycle();
    reset = 0;
    RegWriteM = 0; WA3M = 0; RA1E = 0;

    // Forwarding priority, then W-only.
    RegWriteM = 1; WA3M = 3; RegWriteW = 1; WA3W = 3; RA1E = 3; RA2E = 15;
    cycle();
    chk("fwd_m_prio", 32'(ForwardAE), 32'd2);
    RegWriteM = 0;
    cycle();
    chk("fwd_w", 32'(ForwardAE), 32'd1);
    WA3W = 15;
    cycle();
    idle_inputs();

    // Load-use for one cycle, then a branch alone.
    MemtoRegE = 1; WA3E = 5; RA2D = 5; RA1D = 1;
    cycle();
    chk("ldr_stallf", 32'(last_stallf), 32'd1);
    MemtoRegE = 0;
    cycle();
    BranchTakenE = 1;
    cycle();
    BranchTakenE = 0;
    cycle();

    // Four-cycle memory wait.
    MemReqM = 1; MemReadyM = 0;
    nst = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (last_stallf) nst++;
    end
    MemReadyM = 1;
    cycle();
    chk("wait4_release", 32'(last_stallf), 32'd0);
    chk("wait4_len", 32'(nst), 32'd4);
    MemReqM = 0; MemReadyM = 0;
    cycle();

    // Watchdog timeout: bounded loop, stall must be exactly MEM_TIMEOUT-1.
    MemReqM = 1; MemReadyM = 0;
    nst = 0;
    for (int i = 0; i < MEM_TIMEOUT + 4; i++) begin
      cycle();
      if (last_stallf) nst++;
      else break;
    end
    chk("timeout_len", 32'(nst), 32'(MEM_TIMEOUT - 1));
    MemReqM = 0;
    cycle();
    chk("timeout_err", 32'(MemErr), 32'd1);
    cycle();

    // Reset during cycle 3 of a wait, then a ready-on-first-cycle access.
    MemReqM = 1; MemReadyM = 0;
    cycle();
    cycle();
    reset = 1;
    cycle();
    reset = 0; MemReadyM = 1;
    cycle();
    chk("post_reset_nostall", 32'(last_stallf), 32'd0);
    MemReqM = 0; MemReadyM = 0;
    cycle();

    // Branch held across a two-cycle wait; counters from a clean reset.
    reset = 1;
    cycle();
    reset = 0;
    MemReqM = 1; MemReadyM = 0; BranchTakenE = 1;
    cycle();
    cycle();
    MemReadyM = 1;
    cycle();
    idle_inputs();
    cycle();
`ifdef HAZARD_PERF_EN
    chk("prio_memwaitcnt", MemWaitCnt, 32'd2);
    chk("prio_flushcnt", FlushCnt, 32'd1);
`endif

    // Randomized traffic; mode picks how eager memory is so timeouts also occur.
    mode = 0;
    for (int i = 0; i < 600; i++) begin
      if (i % 48 == 0) mode = $urandom_range(0, 2);
      reset        = ($urandom_range(0, 99) == 0);
      RA1E = 4'($urandom_range(0, 3)); RA2E = 4'($urandom_range(0, 3));
      RA1D = 4'($urandom_range(0, 3)); RA2D = 4'($urandom_range(0, 3));
      WA3E = 4'($urandom_range(0, 3)); WA3M = 4'($urandom_range(0, 3));
      WA3W = 4'($urandom_range(0, 3));
      RegWriteM    = 1'($urandom);
      RegWriteW    = 1'($urandom);
      MemtoRegE    = ($urandom_range(0, 3) == 0);
      PCWrPendingF = ($urandom_range(0, 5) == 0);
      PCSrcW       = ($urandom_range(0, 7) == 0);
      BranchTakenE = ($urandom_range(0, 5) == 0);
      MemReqM      = ($urandom_range(0, 2) == 0);
      case (mode)
        0:       MemReadyM = ($urandom_range(0, 1) == 0);
        1:       MemReadyM = ($urandom_range(0, 5) == 0);
        default: MemReadyM = ($urandom_range(0, 40) == 0);
      endcase
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline hazard and sequencing controller for the five-stage (F/D/E/M/W) pipelined processor.
- Drives the register-file forwarding muxes in E, and the stall/flush enables of the F/D, D/E, E/M and M/W pipeline registers.
- Resolves load-use stalls, PC-write and branch redirects, and multi-cycle data-memory waits.
- Contains the memory-wait FSM with a timeout watchdog and a sticky error flag.

Parameters:
- MEM_TIMEOUT, 16, max cycles a data access may be held in WAIT before it is abandoned (legal range 2..255).
- CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- RA1E, RA2E  in  4 each  source register addresses in E
- RA1D, RA2D  in  4 each  source register addresses in D
- WA3E, WA3M, WA3W  in  4 each  destination register addresses in E/M/W
- RegWriteM, RegWriteW  in  1 each  register write enables in M/W
- MemtoRegE  in  1  instruction in E is a load
- PCWrPendingF  in  1  PCSrcD|PCSrcE|PCSrcM (PC write in flight)
- PCSrcW  in  1  PC write in W
- BranchTakenE  in  1  branch resolved taken in E
- MemReqM  in  1  data-memory access active in M
- MemReadyM  in  1  memory completes the access this cycle
- ForwardAE, ForwardBE  out  2 each  00 = register file, 01 = ResultW, 10 = ALUOutM
- StallF, StallD, StallE, StallM  out  1 each  hold the pipeline register
- FlushD, FlushE, FlushW  out  1 each  clear the pipeline register (bubble)
- MemErr  out  1  sticky memory-timeout error

Behaviour:
- Outputs are combinational from the inputs and the registered state.
- While reset=1:
  - ForwardAE = ForwardBE = 00.
  - All Stall* = 0.
  - FlushD = FlushE = 1; FlushW = 0.
  - MemErr = 0; FSM = IDLE; counter = 0.
  - Reset mid-WAIT aborts the wait with no error.
- Forwarding (per operand, shown for A):
  - 10 if RegWriteM & WA3M==RA1E.
  - Else 01 if RegWriteW & WA3W==RA1E.
  - Else 00.
  - M has priority over W. Address 15 is forwarded like any other register.
- ldrStall = MemtoRegE & (WA3E==RA1D | WA3E==RA2D).
- Normal (no memory wait):
  - StallF = ldrStall | PCWrPendingF.
  - StallD = ldrStall.
  - FlushE = ldrStall | BranchTakenE.
  - FlushD = PCWrPendingF | PCSrcW | BranchTakenE.
  - StallE = StallM = FlushW = 0.
- memStall = (state==IDLE & MemReqM & ~MemReadyM) | (state==WAIT & ~MemReadyM & ~timeout).
- When memStall=1, it overrides all other terms:
  - StallF = StallD = StallE = StallM = 1.
  - FlushD = FlushE = 0.
  - FlushW = 1.
  - A branch or load-use in E is held and takes effect the cycle after release.
- FSM states:
  - IDLE: if MemReqM & ~MemReadyM, go to WAIT and set cnt = 1; otherwise stay.
  - WAIT: if MemReadyM, go to IDLE and set cnt = 0; the stall drops the same cycle (zero extra latency).
  - WAIT timeout: timeout = (cnt == MEM_TIMEOUT-1) & ~MemReadyM. On timeout, the stall drops that cycle, MemErr is set next edge, the FSM goes to IDLE, and the access is treated as complete.
  - Otherwise in WAIT: cnt = cnt+1.
  - Total stall length is at most MEM_TIMEOUT-1 cycles.
- MemReadyM=1 in the same cycle as the request means no stall and no FSM transition.
- MemErr is cleared only by reset. The pipeline keeps running after MemErr is set.
- Back-to-back accesses: a new request in the cycle after release re-enters WAIT normally.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined:
  - Adds outputs StallCnt[31:0], FlushCnt[31:0], MemWaitCnt[31:0], all cleared by reset and wrapping at 2^32.
  - StallCnt increments on cycles with StallD=1.
  - FlushCnt increments on cycles with FlushE=1 from BranchTakenE only.
  - MemWaitCnt increments on cycles with memStall=1.
- When undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Forwarding: RegWriteM=1, WA3M=3, RegWriteW=1, WA3W=3, RA1E=3 -> ForwardAE=10. Drop RegWriteM -> ForwardAE=01.
- Load-use: MemtoRegE=1, WA3E=5, RA2D=5 -> StallF=1, StallD=1, FlushE=1 for exactly one cycle. BranchTakenE=1 alone -> FlushD=FlushE=1, no stall.
- Memory wait:
  - Stimulus: MemReqM=1, MemReadyM low for 4 cycles, then high.
  - Required: StallF/D/E/M=1 and FlushW=1 for 4 cycles, all 0 on the ready cycle; MemErr stays 0.
- Timeout (MEM_TIMEOUT=16):
  - Stimulus: MemReqM=1, MemReadyM held 0.
  - Required: stall for exactly 15 cycles, released on the 16th; MemErr=1 from the next edge, held until reset.
- Reset mid-WAIT:
  - Stimulus: assert reset during cycle 3 of a wait.
  - Required: stalls=0, FlushD=FlushE=1, FSM IDLE, MemErr=0. After reset, a ready-on-first-cycle access produces no stall.
- Priority (with HAZARD_PERF_EN):
  - Stimulus: BranchTakenE=1 during a 2-cycle memory wait.
  - Required: FlushE=0 during the wait, FlushE=1 on the release cycle; MemWaitCnt=2, FlushCnt=1.
